// File: rtl/m_isa_pkg.sv
// Shared ISA definitions for m_fetch / m_control: instruction width, field
// positions, halt sentinel and fetch sequencer states.
package m_isa_pkg;

   localparam int unsigned INSTR_W  = 20;

   localparam int unsigned MC_MSB   = 19;
   localparam int unsigned MC_LSB   = 18;
   localparam int unsigned OPA_MSB  = 17;
   localparam int unsigned OPA_LSB  = 13;
   localparam int unsigned ALUC_MSB = 12;
   localparam int unsigned ALUC_LSB = 10;
   localparam int unsigned OPB_MSB  = 9;
   localparam int unsigned OPB_LSB  = 5;
   localparam int unsigned MEMB_MSB = 4;
   localparam int unsigned MEMB_LSB = 0;

   localparam logic [INSTR_W-1:0] HALT_WORD = 20'hFFFFF;

   // HOLD is only reachable when single-step gating is compiled in
   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      ISSUE,
      HALT,
      HOLD
   } fetch_state_e;

   function automatic logic is_halt(input logic [INSTR_W-1:0] w);
      return w == HALT_WORD;
   endfunction

endpackage

// File: rtl/m_fetch_if.sv
// Instruction handshake between m_fetch (master) and m_control (slave).
interface m_fetch_if;
   import m_isa_pkg::*;

   logic [INSTR_W-1:0] instruccion;
   logic               instr_valid;
   logic               instr_ready;

   modport master (output instruccion, output instr_valid, input  instr_ready);
   modport slave  (input  instruccion, input  instr_valid, output instr_ready);

endinterface

// File: rtl/m_instr_mem.sv
// DEPTH x W instruction memory: one write port, one registered read port,
// no reset. A write to the address being read returns the new data.
module m_instr_mem #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned AW    = 5,
   parameter int unsigned W     = 20
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (we_i && (waddr_i == raddr_i)) begin
         rdata_q <= wdata_i;
      end else begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/m_fetch.sv
// Instruction fetch sequencer feeding m_control over m_fetch_if.
// Optional `FETCH_SINGLE_STEP_EN adds a `step` input gating every entry to FETCH.
module m_fetch
   import m_isa_pkg::*;
#(
   parameter int unsigned          DEPTH     = 32,
   parameter int unsigned          AW        = 5,
   parameter logic [INSTR_W-1:0]   HALT_WORD = m_isa_pkg::HALT_WORD
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               prog_we,
   input  logic [AW-1:0]      prog_addr,
   input  logic [INSTR_W-1:0] prog_data,
   m_fetch_if.master          bus,
`ifdef FETCH_SINGLE_STEP_EN
   input  logic               step,
`endif
   output logic [AW-1:0]      pc,
   output logic               busy,
   output logic               halted
);

   fetch_state_e       state_q, state_d;
   logic [AW-1:0]      pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               valid_q, valid_d;
   logic               mem_we;
   logic [INSTR_W-1:0] rd_data;
   logic               go;

`ifdef FETCH_SINGLE_STEP_EN
   assign go = step;
`else
   assign go = 1'b1;
`endif

   // Read address is the next pc, so the word is already registered during FETCH
   m_instr_mem #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .W     (INSTR_W)
   ) u_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (prog_addr),
      .wdata_i (prog_data),
      .raddr_i (pc_d),
      .rdata_o (rd_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= '0;
         instr_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      mem_we  = 1'b0;

      unique case (state_q)
         IDLE, HALT: begin
            mem_we = prog_we;
            if (start) begin
               pc_d    = '0;
               state_d = go ? FETCH : HOLD;
            end
         end
         HOLD: begin
            if (go) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (rd_data == HALT_WORD) begin
               state_d = HALT;
            end else begin
               instr_d = rd_data;
               valid_d = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (valid_q && bus.instr_ready) begin
               valid_d = 1'b0;
               if (pc_q == AW'(DEPTH - 1)) begin
                  state_d = HALT;
               end else begin
                  pc_d    = pc_q + 1'b1;
                  state_d = go ? FETCH : HOLD;
               end
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   assign bus.instruccion = instr_q;
   assign bus.instr_valid = valid_q;
   assign pc              = pc_q;
   assign busy            = (state_q == FETCH) || (state_q == ISSUE) || (state_q == HOLD);
   assign halted          = (state_q == HALT);

endmodule

// File: tb/tb_m_fetch.sv
// Scoreboard bench for m_fetch: expected (pc, instruction) pairs are queued
// at start and popped on each accepted transfer.
module tb_m_fetch;
   import m_isa_pkg::*;

   localparam int unsigned DEPTH = 32;
   localparam int unsigned AW    = 5;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               prog_we;
   logic [AW-1:0]      prog_addr;
   logic [INSTR_W-1:0] prog_data;
   logic               step;
   logic [AW-1:0]      pc;
   logic               busy;
   logic               halted;

   m_fetch_if bus ();

   m_fetch #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .bus       (bus),
`ifdef FETCH_SINGLE_STEP_EN
      .step      (step),
`endif
      .pc        (pc),
      .busy      (busy),
      .halted    (halted)
   );

   always #5 clk = ~clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned xfers   = 0;
   logic [AW+INSTR_W-1:0] sb[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Monitor: every accepted transfer must match the head of the scoreboard
   always @(negedge clk) begin
      if (!rst && bus.instr_valid && bus.instr_ready) begin
         xfers++;
         if (sb.size() == 0) begin
            check_eq("unexpected_xfer", {12'd0, bus.instruccion}, 32'd0);
         end else begin
            logic [AW+INSTR_W-1:0] e;
            e = sb.pop_front();
            check_eq("xfer_instr", {12'd0, bus.instruccion}, {12'd0, e[INSTR_W-1:0]});
            check_eq("xfer_pc", {27'd0, pc}, {27'd0, e[AW+INSTR_W-1:INSTR_W]});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [INSTR_W-1:0] d);
      prog_we = 1'b1; prog_addr = a; prog_data = d;
      tick();
      prog_we = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic push(input int unsigned p, input logic [INSTR_W-1:0] d);
      logic [AW-1:0] pa;
      pa = AW'(p);
      sb.push_back({pa, d});
   endtask

   task automatic wait_halt(input int unsigned budget);
      for (int unsigned i = 0; i < budget && !halted; i++) tick();
      check_eq("halt_reached", {31'd0, halted}, 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      tick();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      step = 1'b1;
      bus.instr_ready = 1'b0;

      // 1. reset state
      tick(); tick();
      check_eq("rst_valid",  {31'd0, bus.instr_valid}, 32'd0);
      check_eq("rst_pc",     {27'd0, pc}, 32'd0);
      check_eq("rst_busy",   {31'd0, busy}, 32'd0);
      check_eq("rst_halted", {31'd0, halted}, 32'd0);
      rst = 1'b0;
      tick();

      // 2. short program, ready held high
      wr(5'd0, 20'h4A5C3);
      wr(5'd1, 20'h80021);
      wr(5'd2, HALT_WORD);
      bus.instr_ready = 1'b1;
      xfers = 0;
      push(0, 20'h4A5C3);
      push(1, 20'h80021);
      pulse_start();
      check_eq("lat_fetch_valid", {31'd0, bus.instr_valid}, 32'd0);
      check_eq("lat_fetch_busy",  {31'd0, busy}, 32'd1);
      tick();
      check_eq("lat_issue_valid", {31'd0, bus.instr_valid}, 32'd1);
      check_eq("lat_issue_instr", {12'd0, bus.instruccion}, 32'h4A5C3);
      wait_halt(20);
      tick();
      check_eq("t2_xfers",    xfers, 32'd2);
      check_eq("t2_sb_empty", sb.size(), 32'd0);
      check_eq("t2_halt_pc",  {27'd0, pc}, 32'd2);
      check_eq("t2_busy",     {31'd0, busy}, 32'd0);

      // 3. back-pressure at pc 0, then async reset mid-ISSUE
      bus.instr_ready = 1'b0;
      pulse_start();
      tick();
      for (int unsigned i = 0; i < 5; i++) begin
         check_eq("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
         check_eq("stall_instr", {12'd0, bus.instruccion}, 32'h4A5C3);
         check_eq("stall_pc",    {27'd0, pc}, 32'd0);
         tick();
      end
      rst = 1'b1;
      #1;
      check_eq("arst_valid",  {31'd0, bus.instr_valid}, 32'd0);
      check_eq("arst_pc",     {27'd0, pc}, 32'd0);
      check_eq("arst_busy",   {31'd0, busy}, 32'd0);
      check_eq("arst_halted", {31'd0, halted}, 32'd0);
      check_eq("arst_instr",  {12'd0, bus.instruccion}, 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // 4. full memory, halt at last address without wrap
      for (int unsigned a = 0; a < DEPTH; a++) wr(AW'(a), 20'h00001);
      bus.instr_ready = 1'b1;
      xfers = 0;
      for (int unsigned a = 0; a < DEPTH; a++) push(a, 20'h00001);
      pulse_start();
      wait_halt(200);
      tick(); tick();
      check_eq("t4_xfers",    xfers, 32'd32);
      check_eq("t4_sb_empty", sb.size(), 32'd0);
      check_eq("t4_pc",       {27'd0, pc}, 32'd31);
      check_eq("t4_halted",   {31'd0, halted}, 32'd1);
      check_eq("t4_valid",    {31'd0, bus.instr_valid}, 32'd0);

      // 5. write+start in one IDLE cycle; write during ISSUE ignored
      do_reset();
      bus.instr_ready = 1'b0;
      xfers = 0;
      push(0, 20'h12345);
      for (int unsigned a = 1; a < DEPTH; a++) push(a, 20'h00001);
      prog_we = 1'b1; prog_addr = 5'd0; prog_data = 20'h12345; start = 1'b1;
      tick();
      prog_we = 1'b0; start = 1'b0;
      for (int unsigned i = 0; i < 10 && !bus.instr_valid; i++) tick();
      check_eq("t5_valid", {31'd0, bus.instr_valid}, 32'd1);
      wr(5'd1, 20'hABCDE);
      bus.instr_ready = 1'b1;
      wait_halt(200);
      tick();
      check_eq("t5_xfers",    xfers, 32'd32);
      check_eq("t5_sb_empty", sb.size(), 32'd0);

`ifdef FETCH_SINGLE_STEP_EN
      // 6. step gating: nothing without step, one instruction per step pulse
      do_reset();
      wr(5'd0, 20'h4A5C3);
      wr(5'd1, 20'h80021);
      step = 1'b0;
      xfers = 0;
      pulse_start();
      for (int unsigned i = 0; i < 6; i++) begin
         check_eq("t6_nostep_valid", {31'd0, bus.instr_valid}, 32'd0);
         check_eq("t6_nostep_busy",  {31'd0, busy}, 32'd1);
         tick();
      end
      push(0, 20'h4A5C3);
      step = 1'b1;
      tick();
      step = 1'b0;
      repeat (6) tick();
      check_eq("t6_xfers", xfers, 32'd1);
      check_eq("t6_pc",    {27'd0, pc}, 32'd1);
      check_eq("t6_busy",  {31'd0, busy}, 32'd1);
      check_eq("t6_valid", {31'd0, bus.instr_valid}, 32'd0);
      check_eq("t6_sb_empty", sb.size(), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
